// File: rtl/simple_cpu_alu_if.sv
// Operand/result bundle between the accumulator CPU datapath and its ALU.
// The CPU side (master) presents the A/B registers and the operation select;
// the ALU side (slave) returns the combinational result and registered flags.
interface simple_cpu_alu_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic [WIDTH-1:0] out;
   logic             flag_zero;
   logic             flag_carry;
   logic             flag_negative;
   logic             flag_overflow;

   modport master (
      output a,
      output b,
      output sub,
      input  out,
      input  flag_zero,
      input  flag_carry,
      input  flag_negative,
      input  flag_overflow
   );

   modport slave (
      input  a,
      input  b,
      input  sub,
      output out,
      output flag_zero,
      output flag_carry,
      output flag_negative,
      output flag_overflow
   );

endinterface

// File: rtl/simple_cpu_alu.sv
// Add/subtract ALU for the 4-bit-PC accumulator CPU.
// The result is purely combinational so the CPU can write it back to A in the
// second execute cycle; the four status flags are registered one cycle behind
// the result and feed the JZ decision and the logic-analyzer readout.
module simple_cpu_alu #(
   parameter int WIDTH = 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   simple_cpu_alu_if.slave   alu
);

   logic [WIDTH-1:0] bEff;
   logic [WIDTH-1:0] sum;
   logic             carryOut;

   logic             flagZero_d;
   logic             flagCarry_d;
   logic             flagNegative_d;
   logic             flagOverflow_d;

   logic             flagZero_q;
   logic             flagCarry_q;
   logic             flagNegative_q;
   logic             flagOverflow_q;

   // Single ripple-carry adder; subtract reuses it as a + ~b + 1 by inverting
   // the second operand and feeding sub in as the carry-in.
   always_comb begin
      logic ripple;
      bEff   = alu.sub ? ~alu.b : alu.b;
      sum    = '0;
      ripple = alu.sub;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = alu.a[i] ^ bEff[i] ^ ripple;
         ripple = (alu.a[i] & bEff[i]) | (ripple & (alu.a[i] ^ bEff[i]));
      end
      carryOut = ripple;
   end

   // Flag values for the operation currently presented; carry doubles as
   // NOT-borrow on subtract because of the inverted-operand formulation.
   always_comb begin
      flagZero_d     = (sum == '0);
      flagCarry_d    = carryOut;
      flagNegative_d = sum[WIDTH-1];
      flagOverflow_d = (alu.a[WIDTH-1] == bEff[WIDTH-1]) &&
                       (sum[WIDTH-1] != alu.a[WIDTH-1]);
   end

   // Flags sample the result on every edge with no enable; reset wins.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         flagZero_q     <= 1'b0;
         flagCarry_q    <= 1'b0;
         flagNegative_q <= 1'b0;
         flagOverflow_q <= 1'b0;
      end else begin
         flagZero_q     <= flagZero_d;
         flagCarry_q    <= flagCarry_d;
         flagNegative_q <= flagNegative_d;
         flagOverflow_q <= flagOverflow_d;
      end
   end

   assign alu.out           = sum;
   assign alu.flag_zero     = flagZero_q;
   assign alu.flag_carry    = flagCarry_q;
   assign alu.flag_negative = flagNegative_q;
   assign alu.flag_overflow = flagOverflow_q;

endmodule

// File: tb/tb_simple_cpu_alu.sv
// Self-checking bench for simple_cpu_alu: every operation pushes its expected
// flags into a scoreboard queue, and they are popped and compared after the
// sampling edge. The combinational result is checked before the edge.
module tb_simple_cpu_alu;

   localparam int WIDTH = 8;

   logic clk;
   logic rst;

   simple_cpu_alu_if #(.WIDTH(WIDTH)) bus ();

   simple_cpu_alu #(.WIDTH(WIDTH)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .alu      (bus.slave)
   );

   int checkCount = 0;
   int passCount  = 0;

   logic [3:0] flagQueue[$];
   logic [3:0] lastFlags;
   bit         haveLast = 0;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   // Reference model built from plain integer arithmetic.
   task automatic modelAlu(input logic [7:0] a, input logic [7:0] b, input logic sub,
                           output logic [7:0] res, output logic [3:0] flags);
      int ua, ub, ur, sa, sb, sr;
      logic carry, ovf;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sub) begin
         ur    = ua - ub;
         sr    = sa - sb;
         carry = (ua >= ub);
      end else begin
         ur    = ua + ub;
         sr    = sa + sb;
         carry = (ur > 255);
      end
      res   = ur[7:0];
      ovf   = (sr > 127) || (sr < -128);
      flags = {res == 8'h00, carry, res[7], ovf};
   endtask

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic sub, input logic rstIn, input string tag);
      logic [7:0] expOut;
      logic [3:0] expFlags;
      logic [3:0] got;
      @(negedge clk);
      bus.a   = a;
      bus.b   = b;
      bus.sub = sub;
      rst     = rstIn;
      #1;
      modelAlu(a, b, sub, expOut, expFlags);
      checkOutput({tag, ".out"}, 32'(bus.out), 32'(expOut));
      got = {bus.flag_zero, bus.flag_carry, bus.flag_negative, bus.flag_overflow};
      if (haveLast) checkOutput({tag, ".flagsHold"}, 32'(got), 32'(lastFlags));
      flagQueue.push_back(rstIn ? 4'b0000 : expFlags);
      @(posedge clk);
      #1;
      got = {bus.flag_zero, bus.flag_carry, bus.flag_negative, bus.flag_overflow};
      if (flagQueue.size() == 0) begin
         checkOutput({tag, ".queueEmpty"}, 32'd0, 32'd1);
      end else begin
         lastFlags = flagQueue.pop_front();
         haveLast  = 1;
         checkOutput({tag, ".flags"}, 32'(got), 32'(lastFlags));
      end
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic       rs;
      rst     = 1'b1;
      bus.a   = '0;
      bus.b   = '0;
      bus.sub = 1'b0;

      // Reset held for two cycles with zero operands.
      applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, "reset0");
      applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, "reset1");

      // Directed cases including the boundary conditions.
      applyStimulus(8'h05, 8'h03, 1'b0, 1'b0, "add5p3");
      applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, "addWrap");
      applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, "addOvf");
      applyStimulus(8'h0A, 8'h0A, 1'b1, 1'b0, "subEq");
      applyStimulus(8'h03, 8'h05, 1'b1, 1'b0, "subBorrow");
      applyStimulus(8'h80, 8'h01, 1'b1, 1'b0, "subOvf");
      applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, "zeroMinusZero");
      applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, "zeroPlusZero");
      // Zero result followed by nonzero: flagsHold shows zero stays 1 pre-edge.
      applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, "zeroDrop");
      applyStimulus(8'h12, 8'h34, 1'b1, 1'b0, "subToggle");
      applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, "addNegOvf");
      // Reset with a zero result: flags must stay cleared, out keeps tracking.
      applyStimulus(8'h55, 8'h55, 1'b1, 1'b1, "rstZero");
      applyStimulus(8'hC8, 8'h64, 1'b0, 1'b1, "rstNonzero");
      applyStimulus(8'h01, 8'hFF, 1'b1, 1'b0, "afterRst");

      // Random operations with sub toggling freely.
      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rs = 1'($urandom_range(0, 1));
         applyStimulus(ra, rb, rs, 1'b0, "rand");
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/simple_cpu_alu.md
Name: simple_cpu_alu

Overview:
- 8-bit add/subtract datapath for the 4-bit-PC accumulator CPU in the user project.
- Takes the A register as `a` and the B register as `b`.
- Produces a combinational result that the CPU writes back to A in execute cycle 2.
- Holds registered status flags for conditional jumps (JZ) and for logic-analyzer readout.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 2.

Ports:
- wb_clk_i  input  1  system clock; all flag registers update on the rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- a  input  WIDTH  left operand (minuend for subtract).
- b  input  WIDTH  right operand (subtrahend for subtract).
- sub  input  1  0 = add (a+b), 1 = subtract (a-b).
- out  output  WIDTH  combinational result, low WIDTH bits.
- flag_zero  output  1  registered: last sampled result was all zeros.
- flag_carry  output  1  registered: carry-out of the adder for the last sampled operation.
- flag_negative  output  1  registered: MSB of the last sampled result.
- flag_overflow  output  1  registered: signed two's-complement overflow of the last sampled operation.

Behaviour:
- Arithmetic core:
  - Single WIDTH-bit ripple-carry adder.
  - Second operand is b when sub=0, and ~b when sub=1.
  - Carry-in equals sub, so subtract is a + ~b + 1.
  - out = low WIDTH bits of the sum; wraps modulo 2^WIDTH.
- Combinational path:
  - out is purely combinational from a, b and sub, with no clock latency.
  - out does not depend on reset and is valid in the same cycle the inputs settle.
- Carry semantics:
  - Add: flag_carry = unsigned overflow (sum >= 2^WIDTH).
  - Subtract: flag_carry = NOT borrow; 1 when a >= b unsigned, 0 when a < b.
- Overflow: (a[MSB] == b_eff[MSB]) && (out[MSB] != a[MSB]), where b_eff is the post-inversion operand.
- Flag registers:
  - On every rising edge of wb_clk_i with wb_rst_i=0, all four flags load from the current combinational result.
  - There is no enable; flags lag out by exactly one cycle.
  - The CPU relies on this because a_reg/b_reg are stable across the two-cycle instruction.
- Reset:
  - wb_rst_i=1 at a rising edge clears flag_zero, flag_carry, flag_negative and flag_overflow to 0.
  - Reset has priority over flag update.
  - Asserting reset mid-operation affects only the flags; out keeps tracking its inputs.
- Boundary cases:
  - a=b with sub=1 gives out=0, zero=1, carry=1.
  - 0-0 gives zero=1, carry=1.
  - 0+0 gives zero=1, carry=0.
  - Max+1 wraps to 0 with zero=1 and carry=1.
  - sub may toggle on any cycle; the flags reflect the operation presented at the sampling edge.
- X-safety: no latches; every output is driven in every state.

Test Plan:
- Reset: hold wb_rst_i=1 for 2 cycles with a=0, b=0 -> all flags 0 after the edge; out=0x00 combinationally.
- Add: a=0x05, b=0x03, sub=0 -> out=0x08 immediately; after the next edge zero=0, carry=0, negative=0, overflow=0.
- Add wrap: a=0xFF, b=0x01, sub=0 -> out=0x00; after the edge zero=1, carry=1, overflow=0. Then a=0x7F, b=0x01 -> out=0x80, negative=1, overflow=1, carry=0.
- Subtract: a=0x0A, b=0x0A, sub=1 -> out=0x00, zero=1, carry=1. Then a=0x03, b=0x05, sub=1 -> out=0xFE, zero=0, carry=0, negative=1.
- Signed overflow on subtract: a=0x80, b=0x01, sub=1 -> out=0x7F, overflow=1, carry=1, negative=0.
- Flag latency and reset priority:
  - Change operands from a zero result to a nonzero result -> flag_zero stays 1 until the next edge, then drops.
  - Assert wb_rst_i together with a zero result -> flags stay 0.
